boothr4_datapath: RTL

Arithmetic datapath for the radix-4 Booth multiplier; sits directly downstream of the Booth control unit.
- Consumes its 9-bit one-hot-per-micro-op control word; returns the 3-bit recoding window q_reg that the control unit decodes.
- Holds multiplicand M, accumulator A, multiplier/low-product Q and guard bit Q[-1].
- Emits the signed 2N-bit product on an N-bit output bus over two beats, high byte first.

---
 rtl/boothr4_pkg.sv | 17 +
 rtl/boothr4_addsub.sv | 21 ++
 rtl/boothr4_datapath.sv | 84 ++++++++
 3 files changed

// File: rtl/boothr4_pkg.sv
// Shared constants for the radix-4 Booth multiplier datapath: operand widths
// and bit positions of the micro-op control word.
package boothr4_pkg;
   localparam int N  = 8;
   localparam int AW = N + 2;
   localparam int CW = 9;

   localparam int C_LOAD_M = 0;
   localparam int C_LOAD_Q = 1;
   localparam int C_ADD    = 2;
   localparam int C_SUB    = 3;
   localparam int C_DBL    = 4;
   localparam int C_SHIFT  = 5;
   localparam int C_CNT    = 6;
   localparam int C_OUT_HI = 7;
   localparam int C_OUT_LO = 8;
endpackage

// File: rtl/boothr4_addsub.sv
// Accumulator adder: A + {+M, -M, +2M, -2M}, with M sign-extended to AW bits.
module boothr4_addsub
   import boothr4_pkg::*;
(
   input  logic [AW-1:0] a,
   input  logic [N-1:0]  m,
   input  logic          sub,
   input  logic          dbl,
   output logic [AW-1:0] sum
);
   logic [AW-1:0] m_ext;
   logic [AW-1:0] op_mag;
   logic [AW-1:0] op;

   always_comb begin
      m_ext  = {{(AW-N){m[N-1]}}, m};
      op_mag = dbl ? (m_ext << 1) : m_ext;
      op     = sub ? (~op_mag + AW'(1)) : op_mag;
      sum    = a + op;
   end
endmodule

// File: rtl/boothr4_datapath.sv
// Radix-4 Booth datapath: M/A/Q/Q[-1] registers, 2-bit arithmetic shifter,
// and a two-beat product output (high half then low half).
module boothr4_datapath
   import boothr4_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  inbus,
   input  logic [CW-1:0] control,
   output logic [2:0]    q_reg,
   output logic [N-1:0]  outbus,
   output logic          outvalid
);
   logic [N-1:0]  m_q, m_d;
   logic [AW-1:0] a_q, a_d;
   logic [N-1:0]  q_q, q_d;
   logic          qm1_q, qm1_d;
   logic [N-1:0]  outbus_q, outbus_d;
   logic          outvalid_q, outvalid_d;

   logic [AW-1:0]   sum;
   logic [AW-1:0]   a_sel;
   logic [AW+N:0]   shv;
   logic            cnt_unused;

   assign cnt_unused = control[C_CNT];

   boothr4_addsub u_addsub (
      .a   (a_q),
      .m   (m_q),
      .sub (control[C_SUB]),
      .dbl (control[C_DBL]),
      .sum (sum)
   );

   always_comb begin
      m_d        = m_q;
      a_d        = a_q;
      q_d        = q_q;
      qm1_d      = qm1_q;
      outbus_d   = outbus_q;
      a_sel      = control[C_ADD] ? sum : a_q;
      shv        = {a_sel, q_q, qm1_q};

      if (control[C_LOAD_M]) m_d = inbus;

      // A Q load overrides any add/shift issued in the same cycle.
      if (control[C_LOAD_Q]) begin
         q_d   = inbus;
         a_d   = '0;
         qm1_d = 1'b0;
      end else if (control[C_SHIFT]) begin
         {a_d, q_d, qm1_d} = {{2{shv[AW+N]}}, shv[AW+N:2]};
      end else begin
         a_d = a_sel;
      end

      if (control[C_OUT_LO])      outbus_d = q_q;
      else if (control[C_OUT_HI]) outbus_d = a_q[N-1:0];
      outvalid_d = control[C_OUT_HI] | control[C_OUT_LO];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q        <= '0;
         a_q        <= '0;
         q_q        <= '0;
         qm1_q      <= 1'b0;
         outbus_q   <= '0;
         outvalid_q <= 1'b0;
      end else begin
         m_q        <= m_d;
         a_q        <= a_d;
         q_q        <= q_d;
         qm1_q      <= qm1_d;
         outbus_q   <= outbus_d;
         outvalid_q <= outvalid_d;
      end
   end

   assign q_reg    = {q_q[1:0], qm1_q};
   assign outbus   = outbus_q;
   assign outvalid = outvalid_q;
endmodule
